// File: rtl/byte_stream_mem_writer_pkg.sv
// Shared types and helpers for the byte-stream-to-RAM writer.
package byte_stream_mem_writer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    LAST_WR = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  // Number of filled lanes (0..4) to a contiguous low-lane byteenable mask.
  function automatic logic [BYTES_PER_WORD-1:0] lanes_to_be(input logic [LANE_W:0] lanes);
    logic [BYTES_PER_WORD-1:0] be;
    be = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (i < int'(lanes)) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/byte_stream_mem_writer_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; word_o already
// includes the byte being accepted this cycle.
module byte_packer_4to32
  import byte_stream_mem_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [7:0]        data_i,
  output logic [LANE_W-1:0] lane_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_ready_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] pack_q, pack_d;

  always_comb begin
    word_o = pack_q;
    if (accept_i) word_o[{lane_q, 3'b000} +: 8] = data_i;
    word_ready_o = accept_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    lane_d = lane_q;
    pack_d = pack_q;
    if (clear_i) begin
      lane_d = '0;
      pack_d = '0;
    end else if (accept_i) begin
      // Lane counter wraps 3->0 naturally; a completed word leaves zeros behind.
      lane_d = lane_q + 1'b1;
      pack_d = word_ready_o ? '0 : word_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

  assign lane_o = lane_q;

endmodule

// File: rtl/byte_stream_mem_writer.sv
// Captures a byte stream into the on-chip RAM through an Avalon-MM write
// master, with fixed-length or circular capture and CSR-visible status.
module byte_stream_mem_writer
  import byte_stream_mem_writer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   word_count,
  input  logic              wrap_en,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic              avm_clken,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     target_q;
  logic                wrap_q;
  logic                wrapped_q;
  logic                done_q;
  logic                wr_q;
  logic [3:0]          be_q;
  logic [WORD_W-1:0]   data_q;

  logic                accept;
  logic                word_ready;
  logic [LANE_W-1:0]   lane;
  logic [WORD_W-1:0]   packed_word;
  logic [LANE_W:0]     pending;
  logic                final_word;

  assign accept     = s_valid && (state_q == CAPTURE);
  assign pending    = {1'b0, lane} + {{LANE_W{1'b0}}, accept};
  assign final_word = !wrap_q && (count_q == target_q - 1'b1);

  byte_packer_4to32 u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (state_q != CAPTURE),
    .accept_i     (accept),
    .data_i       (s_data),
    .lane_o       (lane),
    .word_o       (packed_word),
    .word_ready_o (word_ready)
  );

  // Control FSM; the write strobe and its payload are registered so each
  // write appears in the cycle after the byte that completed it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      target_q  <= '0;
      wrap_q    <= 1'b0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      data_q    <= '0;
    end else begin
      wr_q   <= 1'b0;
      be_q   <= '0;
      data_q <= '0;

      if (wr_q) begin
        addr_q <= addr_q + 1'b1;
        if (wrap_q && (addr_q == LAST_ADDR)) wrapped_q <= 1'b1;
        if (count_q != DEPTH_CNT) count_q <= count_q + 1'b1;
      end

      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= CAPTURE;
            addr_q    <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= wrap_en;
            target_q  <= (word_count == '0) ? DEPTH_CNT : word_count;
          end
        end
        CAPTURE: begin
          if (word_ready) begin
            wr_q   <= 1'b1;
            be_q   <= lanes_to_be((LANE_W + 1)'(BYTES_PER_WORD));
            data_q <= packed_word;
            if (final_word || stop) state_q <= LAST_WR;
          end else if (stop) begin
            // Flush whatever lanes are filled; an empty word produces no write.
            state_q <= LAST_WR;
            if (pending != '0) begin
              wr_q   <= 1'b1;
              be_q   <= lanes_to_be(pending);
              data_q <= packed_word;
            end
          end
        end
        LAST_WR: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready        = (state_q == CAPTURE);
  assign busy           = (state_q == CAPTURE) || (state_q == LAST_WR);
  assign done           = done_q;
  assign wrapped        = wrapped_q;
  assign words_written  = count_q;
  assign avm_address    = addr_q;
  assign avm_write      = wr_q;
  assign avm_chipselect = wr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = data_q;
  assign avm_clken      = 1'b1;

endmodule
